// File: rtl/line_fetch_dma_if.sv
// wishbone_b3: Wishbone B3 bus with registered-feedback burst tags
interface wishbone_b3;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;
  modport master (output cyc, stb, we, sel, adr, dat_m2s, cti, bte, input dat_s2m, ack, err, rty);
  modport slave (input cyc, stb, we, sel, adr, dat_m2s, cti, bte, output dat_s2m, ack, err, rty);
endinterface

// File: rtl/line_fetch_dma.sv
// line_fetch_dma: fetches one framebuffer row over Wishbone bursts into a ping-pong line buffer
module line_fetch_dma #(
  parameter int unsigned H_PIXELS     = 800,
  parameter int unsigned V_LINES      = 480,
  parameter logic [31:0] BASE_ADDR    = 32'h0100_0000,
  parameter int unsigned STRIDE_BYTES = 3200,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [8:0]  fetch_row,
  output logic        busy,
  output logic        fetch_done,
  output logic        fetch_err,
  output logic        err_sticky,
  output logic        disp_bank,
  input  logic [9:0]  rd_addr,
  output logic [23:0] rd_data,
  wishbone_b3.master  bus
);
  localparam logic [10:0] BM = 11'(BURST_LEN - 1);
  localparam logic [10:0] HL = 11'(H_PIXELS - 1);
  localparam logic [7:0]  RL = 8'(MAX_RETRY - 1);
  typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;
  state_t      state;
  logic [10:0] pix;
  logic [7:0]  retry;
  logic [23:0] mem [0:2047];
  logic        beat;
  logic        unused_hi;
  assign beat        = state == BURST && bus.ack && !bus.err && !bus.rty;
  assign bus.we      = 1'b0;
  assign bus.sel     = 4'hF;
  assign bus.bte     = 2'b00;
  assign bus.dat_m2s = 32'd0;
  assign unused_hi   = ^bus.dat_s2m[31:24];
  // bursts stay aligned to BURST_LEN pixels; the line end also closes a burst
  function automatic logic [2:0] cti_for(input logic [10:0] p);
    return ((p & BM) == BM || p == HL) ? 3'b111 : 3'b010;
  endfunction
  // fetch sequencer: bus master, retry accounting and bank handover
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bus.cyc    <= 1'b0;
      bus.stb    <= 1'b0;
      bus.adr    <= 32'd0;
      bus.cti    <= 3'b010;
      pix        <= 11'd0;
      retry      <= 8'd0;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      err_sticky <= 1'b0;
      disp_bank  <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      case (state)
        IDLE: if (fetch_start && !fetch_err) begin
          if (32'(fetch_row) >= V_LINES) begin
            fetch_err  <= 1'b1;
            err_sticky <= 1'b1;
          end else begin
            state   <= BURST;
            bus.cyc <= 1'b1;
            bus.stb <= 1'b1;
            busy    <= 1'b1;
            pix     <= 11'd0;
            retry   <= 8'd0;
            bus.adr <= BASE_ADDR + 32'(fetch_row) * 32'(STRIDE_BYTES);
            bus.cti <= cti_for(11'd0);
          end
        end
        BURST: if (bus.err || (bus.rty && retry == RL)) begin
          state      <= IDLE;
          bus.cyc    <= 1'b0;
          bus.stb    <= 1'b0;
          busy       <= 1'b0;
          fetch_err  <= 1'b1;
          err_sticky <= 1'b1;
        end else if (bus.rty) begin
          state   <= GAP;
          bus.cyc <= 1'b0;
          bus.stb <= 1'b0;
          retry   <= retry + 8'd1;
        end else if (bus.ack) begin
          pix     <= pix + 11'd1;
          retry   <= 8'd0;
          bus.adr <= bus.adr + 32'd4;
          bus.cti <= cti_for(pix + 11'd1);
          if (pix == HL) begin
            state      <= DONE;
            bus.cyc    <= 1'b0;
            bus.stb    <= 1'b0;
            busy       <= 1'b0;
            fetch_done <= 1'b1;
            disp_bank  <= ~disp_bank;
          end else if ((pix & BM) == BM) begin
            state   <= GAP;
            bus.cyc <= 1'b0;
            bus.stb <= 1'b0;
          end
        end
        GAP: begin
          state   <= BURST;
          bus.cyc <= 1'b1;
          bus.stb <= 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // line buffer: fetch writes the hidden bank, display reads its own bank one cycle later
  always_ff @(posedge clk) begin
    if (beat) mem[{~disp_bank, pix[9:0]}] <= bus.dat_s2m[23:0];
    rd_data <= mem[{disp_bank, rd_addr}];
  end
endmodule

// File: tb/tb_line_fetch_dma.sv
// tb_line_fetch_dma: directed scoreboard bench with a zero-wait Wishbone slave model
module tb_line_fetch_dma;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int STR = 3200;
  typedef struct packed {logic i; logic [31:0] a; logic [2:0] c;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic fs[2];
  logic [8:0] frow[2];
  logic busy[2], done[2], ferr[2], sticky[2], bank[2];
  logic [9:0] rda[2];
  logic [23:0] rdd[2];
  logic cyc_v[2], stb_v[2], ack_v[2], rty_v[2], err_v[2];
  logic [31:0] adr_v[2], dat_v[2];
  logic [2:0] cti_v[2];
  logic [6:0] ctl_v[2];
  logic [31:0] err_adr[2], rty_adr[2];
  int rty_left[2], done_n[2], err_n[2], done_cyc[2], gapc[2], t0[2];
  logic err_cyc[2], err_busy[2];
  int cnt = 0;
  int checks = 0;
  int errors = 0;
  beat_t sb[$];
  wishbone_b3 b0();
  wishbone_b3 b1();
  line_fetch_dma u0 (
    .clk(clk), .rst(rst), .fetch_start(fs[0]), .fetch_row(frow[0]), .busy(busy[0]),
    .fetch_done(done[0]), .fetch_err(ferr[0]), .err_sticky(sticky[0]), .disp_bank(bank[0]),
    .rd_addr(rda[0]), .rd_data(rdd[0]), .bus(b0)
  );
  line_fetch_dma #(.H_PIXELS(10), .BURST_LEN(4), .MAX_RETRY(2)) u1 (
    .clk(clk), .rst(rst), .fetch_start(fs[1]), .fetch_row(frow[1]), .busy(busy[1]),
    .fetch_done(done[1]), .fetch_err(ferr[1]), .err_sticky(sticky[1]), .disp_bank(bank[1]),
    .rd_addr(rda[1]), .rd_data(rdd[1]), .bus(b1)
  );
  assign cyc_v[0] = b0.cyc;
  assign stb_v[0] = b0.stb;
  assign adr_v[0] = b0.adr;
  assign cti_v[0] = b0.cti;
  assign ctl_v[0] = {b0.we, b0.sel, b0.bte};
  assign b0.ack = ack_v[0];
  assign b0.rty = rty_v[0];
  assign b0.err = err_v[0];
  assign b0.dat_s2m = dat_v[0];
  assign cyc_v[1] = b1.cyc;
  assign stb_v[1] = b1.stb;
  assign adr_v[1] = b1.adr;
  assign cti_v[1] = b1.cti;
  assign ctl_v[1] = {b1.we, b1.sel, b1.bte};
  assign b1.ack = ack_v[1];
  assign b1.rty = rty_v[1];
  assign b1.err = err_v[1];
  assign b1.dat_s2m = dat_v[1];

  function automatic logic [23:0] px(input logic [31:0] a);
    return a[23:0] ^ 24'h5A3C96;
  endfunction

  function automatic logic [31:0] pa(input int row, input int p);
    return BASE + 32'(row * STR) + 32'(p * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_line(input int i, input int row, input int h, input int b);
    beat_t e;
    for (int p = 0; p < h; p++) begin
      e.i = i[0];
      e.a = pa(row, p);
      e.c = (p % b == b - 1 || p == h - 1) ? 3'b111 : 3'b010;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    beat_t e;
    @(negedge clk);
    cnt++;
    for (int i = 0; i < 2; i++) begin
      if (done[i]) begin done_n[i]++; done_cyc[i] = cnt; end
      if (ferr[i]) begin err_n[i]++; err_cyc[i] = cyc_v[i]; err_busy[i] = busy[i]; end
      if (busy[i] && !cyc_v[i]) gapc[i]++;
      ack_v[i] = 1'b0;
      rty_v[i] = 1'b0;
      err_v[i] = 1'b0;
      if (cyc_v[i] && stb_v[i]) begin
        if (adr_v[i] == err_adr[i]) err_v[i] = 1'b1;
        else if (adr_v[i] == rty_adr[i] && rty_left[i] > 0) begin
          rty_v[i] = 1'b1;
          rty_left[i]--;
        end else begin
          ack_v[i] = 1'b1;
          dat_v[i] = {8'hC3, px(adr_v[i])};
          chk("beat_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("beat_inst", 32'(i), 32'(e.i));
            chk("beat_adr", adr_v[i], e.a);
            chk("beat_cti", 32'(cti_v[i]), 32'(e.c));
            chk("beat_ctl", 32'(ctl_v[i]), 32'(7'b0_1111_00));
          end
        end
      end
    end
  endtask

  task automatic start(input int i, input logic [8:0] row);
    frow[i] = row;
    fs[i] = 1'b1;
    t0[i] = cnt;
    tick();
    fs[i] = 1'b0;
  endtask

  task automatic run(input int i, input int budget, input int poke);
    int k = 0;
    while (busy[i] && k < budget) begin
      fs[i] = (k == poke);
      frow[i] = 9'd7;
      tick();
      k++;
    end
    fs[i] = 1'b0;
    chk("run_timeout", 32'(k < budget), 1);
  endtask

  task automatic rdchk(input string tag, input int i, input int a, input logic [23:0] exp);
    rda[i] = 10'(a);
    tick();
    chk(tag, 32'(rdd[i]), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      fs[i] = 1'b0; frow[i] = 9'd0; rda[i] = 10'd0;
      ack_v[i] = 1'b0; rty_v[i] = 1'b0; err_v[i] = 1'b0; dat_v[i] = 32'd0;
      err_adr[i] = '1; rty_adr[i] = '1; rty_left[i] = 0;
      done_n[i] = 0; err_n[i] = 0; done_cyc[i] = 0; gapc[i] = 0; t0[i] = 0;
      err_cyc[i] = 1'b0; err_busy[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_cyc", 32'(cyc_v[i]), 0);
      chk("rst_stb", 32'(stb_v[i]), 0);
      chk("rst_adr", adr_v[i], 0);
      chk("rst_done", 32'(done[i]), 0);
      chk("rst_err", 32'(ferr[i]), 0);
      chk("rst_sticky", 32'(sticky[i]), 0);
      chk("rst_bank", 32'(bank[i]), 0);
    end
    rst = 1'b0;
    tick();
    // full default line, row 2, with a start pulse while busy
    push_line(0, 2, 800, 8);
    gapc[0] = 0;
    start(0, 9'd2);
    chk("t1_busy_n1", 32'(busy[0]), 1);
    chk("t1_cyc_n1", 32'(cyc_v[0]), 1);
    chk("t1_adr_first", adr_v[0], 32'h0100_1900);
    run(0, 2000, 100);
    chk("t1_done_at", 32'(done_cyc[0] - t0[0]), 800 + 100 - 1 + 2 - 1);
    chk("t1_done_n", 32'(done_n[0]), 1);
    chk("t1_gaps", 32'(gapc[0]), 99);
    chk("t1_left", 32'(sb.size()), 0);
    chk("t1_bank", 32'(bank[0]), 1);
    chk("t1_err_n", 32'(err_n[0]), 0);
    fs[0] = 1'b1;
    frow[0] = 9'd3;
    tick();
    fs[0] = 1'b0;
    tick();
    chk("t1_start_on_done_busy", 32'(busy[0]), 0);
    chk("t1_start_on_done_cyc", 32'(cyc_v[0]), 0);
    rdchk("t1_rd5", 0, 5, px(pa(2, 5)));
    // short line with a short final burst
    push_line(1, 1, 10, 4);
    gapc[1] = 0;
    start(1, 9'd1);
    run(1, 200, -1);
    chk("t2_done_at", 32'(done_cyc[1] - t0[1]), 10 + 3 - 1 + 2 - 1);
    chk("t2_gaps", 32'(gapc[1]), 2);
    chk("t2_left", 32'(sb.size()), 0);
    chk("t2_bank", 32'(bank[1]), 1);
    rdchk("t2_rd9", 1, 9, px(pa(1, 9)));
    // two retries at pixel 17 are tolerated with MAX_RETRY=3
    rty_adr[0] = pa(4, 17);
    rty_left[0] = 2;
    push_line(0, 4, 800, 8);
    gapc[0] = 0;
    start(0, 9'd4);
    run(0, 2000, -1);
    rty_adr[0] = '1;
    chk("t3_rty_used", 32'(rty_left[0]), 0);
    chk("t3_done_at", 32'(done_cyc[0] - t0[0]), 900 + 4);
    chk("t3_done_n", 32'(done_n[0]), 2);
    chk("t3_gaps", 32'(gapc[0]), 101);
    chk("t3_err_n", 32'(err_n[0]), 0);
    chk("t3_sticky", 32'(sticky[0]), 0);
    chk("t3_bank", 32'(bank[0]), 0);
    rdchk("t3_rd17", 0, 17, px(pa(4, 17)));
    // the same two retries abort with MAX_RETRY=2
    rty_adr[1] = pa(0, 5);
    rty_left[1] = 2;
    push_line(1, 0, 10, 4);
    start(1, 9'd0);
    run(1, 200, -1);
    rty_adr[1] = '1;
    sb.delete();
    chk("t4_rty_used", 32'(rty_left[1]), 0);
    chk("t4_err_n", 32'(err_n[1]), 1);
    chk("t4_sticky", 32'(sticky[1]), 1);
    chk("t4_bank", 32'(bank[1]), 1);
    chk("t4_done_n", 32'(done_n[1]), 1);
    rdchk("t4_rd5", 1, 5, px(pa(1, 5)));
    // bus error at pixel 300
    err_adr[0] = pa(6, 300);
    push_line(0, 6, 800, 8);
    start(0, 9'd6);
    run(0, 2000, -1);
    err_adr[0] = '1;
    sb.delete();
    chk("t5_err_n", 32'(err_n[0]), 1);
    chk("t5_err_cyc", 32'(err_cyc[0]), 0);
    chk("t5_err_busy", 32'(err_busy[0]), 0);
    chk("t5_sticky", 32'(sticky[0]), 1);
    chk("t5_bank", 32'(bank[0]), 0);
    chk("t5_done_n", 32'(done_n[0]), 2);
    rdchk("t5_rd5", 0, 5, px(pa(4, 5)));
    rdchk("t5_rd300", 0, 300, px(pa(4, 300)));
    // out-of-range row
    start(0, 9'd480);
    chk("t6_err", 32'(ferr[0]), 1);
    chk("t6_cyc", 32'(cyc_v[0]), 0);
    chk("t6_busy", 32'(busy[0]), 0);
    repeat (4) tick();
    chk("t6_err_n", 32'(err_n[0]), 2);
    chk("t6_cyc_later", 32'(cyc_v[0]), 0);
    // reset in the middle of a burst, then a clean fetch
    push_line(0, 9, 800, 8);
    start(0, 9'd9);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    chk("t7_cyc", 32'(cyc_v[0]), 0);
    chk("t7_busy", 32'(busy[0]), 0);
    chk("t7_bank", 32'(bank[0]), 0);
    chk("t7_sticky", 32'(sticky[0]), 0);
    chk("t7_sticky_u1", 32'(sticky[1]), 0);
    rst = 1'b0;
    sb.delete();
    tick();
    push_line(0, 9, 800, 8);
    start(0, 9'd9);
    run(0, 2000, -1);
    chk("t7_done_at", 32'(done_cyc[0] - t0[0]), 900);
    chk("t7_left", 32'(sb.size()), 0);
    chk("t7_bank_after", 32'(bank[0]), 1);
    chk("t7_sticky_after", 32'(sticky[0]), 0);
    rdchk("t7_rd799", 0, 799, px(pa(9, 799)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
